// File: rtl/player_sprite_ctrl_if.sv
// Player sprite controller bus: move requests in, VGA pixel writes and
// status out. The controller uses the master side; a consumer (VGA
// adapter or bench) uses the slave side.
interface player_sprite_ctrl_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           p_up;
  logic           p_down;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [2:0]     colour;
  logic           write_en;
  logic           busy;
  logic           done;
  logic           bump;
  logic [Y_W-1:0] y_pos;

  modport master (
    input  p_up, p_down,
    output x_out, y_out, colour, write_en, busy, done, bump, y_pos
  );

  modport slave (
    output p_up, p_down,
    input  x_out, y_out, colour, write_en, busy, done, bump, y_pos
  );
endinterface

// File: rtl/player_sprite_ctrl.sv
// Player ship sprite engine. Owns the ship's top-row y, accepts single-step
// up/down requests, erases the sprite at the old position, moves with
// clamping, then redraws it pixel by pixel (row-major) at the new position.
// Pixel outputs are decoded from registered state only; bump is the one
// output that depends combinationally on the request inputs.
module player_sprite_ctrl #(
  parameter int                       SPR_W     = 2,
  parameter int                       SPR_H     = 3,
  parameter logic [SPR_W*SPR_H-1:0]   SPR_MASK  = 6'b001100,
  parameter logic [2:0]               FG_COLOUR = 3'b111,
  parameter logic [2:0]               BG_COLOUR = 3'b000,
  parameter int                       X_W       = 8,
  parameter int                       Y_W       = 7,
  parameter int                       X_POS     = 4,
  parameter int                       Y_INIT    = 58,
  parameter int                       Y_MIN     = 0,
  parameter int                       Y_MAX     = 116,
  parameter int                       Y_STEP    = 1
) (
  input logic                 clk,
  input logic                 reset,
  player_sprite_ctrl_if.master bus
);

  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(SPR_W - 1);
  localparam logic [CNT_W-1:0]  ROW_LAST = CNT_W'(SPR_H - 1);
  // Limits are compared one bit wider than y so y + step cannot wrap.
  localparam logic [Y_W:0]      UP_LIMIT = (Y_W+1)'(Y_MIN + Y_STEP);
  localparam logic [Y_W:0]      DN_LIMIT = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]      STEP_EXT = (Y_W+1)'(Y_STEP);
  localparam logic [Y_W-1:0]    STEP_Y   = Y_W'(Y_STEP);
  localparam logic [Y_W-1:0]    INIT_Y   = Y_W'(Y_INIT);
  localparam logic [X_W-1:0]    BASE_X   = X_W'(X_POS);
  // Mask padded to 128 bits so a 7-bit pixel index always fits exactly.
  localparam logic [127:0]      MASK_EXT = 128'(SPR_MASK);

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_INIT_DRAW = 3'd1,
    ST_IDLE      = 3'd2,
    ST_ERASE     = 3'd3,
    ST_UPDATE    = 3'd4,
    ST_DRAW      = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] col_r;
  logic [CNT_W-1:0] row_r;
  logic [Y_W-1:0]   y_pos_r;
  logic             dir_up_r;

  logic             scan_s;
  logic             last_pix_s;
  logic             req_up_s;
  logic             req_dn_s;
  logic             up_ok_s;
  logic             dn_ok_s;
  logic             go_s;
  logic             bump_s;
  logic [6:0]       pix_idx_s;
  logic             mask_bit_s;
  logic [2:0]       colour_s;

  assign scan_s     = (state_r == ST_INIT_DRAW) || (state_r == ST_ERASE) ||
                      (state_r == ST_DRAW);
  assign last_pix_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
  assign req_up_s   = bus.p_up && !bus.p_down;
  assign req_dn_s   = bus.p_down && !bus.p_up;
  assign up_ok_s    = {1'b0, y_pos_r} >= UP_LIMIT;
  assign dn_ok_s    = ({1'b0, y_pos_r} + STEP_EXT) <= DN_LIMIT;
  assign pix_idx_s  = 7'(row_r) * 7'(SPR_W) + 7'(col_r);
  assign mask_bit_s = MASK_EXT[pix_idx_s];

  // State register; reset restarts with the initial sprite paint.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_START;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode, including request legality and the bump pulse.
  always_comb begin
    next_state_s = state_r;
    go_s         = 1'b0;
    bump_s       = 1'b0;
    case (state_r)
      ST_START: begin
        next_state_s = ST_INIT_DRAW;
      end
      ST_INIT_DRAW: begin
        if (last_pix_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_INIT_DRAW;
        end
      end
      ST_IDLE: begin
        if (req_up_s) begin
          if (up_ok_s) begin
            next_state_s = ST_ERASE;
            go_s         = 1'b1;
          end else begin
            bump_s = 1'b1;
          end
        end else if (req_dn_s) begin
          if (dn_ok_s) begin
            next_state_s = ST_ERASE;
            go_s         = 1'b1;
          end else begin
            bump_s = 1'b1;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ERASE: begin
        if (last_pix_s) begin
          next_state_s = ST_UPDATE;
        end else begin
          next_state_s = ST_ERASE;
        end
      end
      ST_UPDATE: begin
        next_state_s = ST_DRAW;
      end
      ST_DRAW: begin
        if (last_pix_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAW;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_START;
      end
    endcase
  end

  // Row-major pixel scan counters; held at zero outside scan states so
  // every scan starts at pixel (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_r <= '0;
      row_r <= '0;
    end else if (scan_s && !last_pix_s) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        row_r <= row_r + 3'd1;
      end else begin
        col_r <= col_r + 3'd1;
      end
    end else begin
      col_r <= '0;
      row_r <= '0;
    end
  end

  // Latch move direction when a legal request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_up_r <= 1'b0;
    end else if (go_s) begin
      dir_up_r <= req_up_s;
    end
  end

  // Committed position; legality was already checked, so no clamp here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_pos_r <= INIT_Y;
    end else if (state_r == ST_UPDATE) begin
      if (dir_up_r) begin
        y_pos_r <= y_pos_r - STEP_Y;
      end else begin
        y_pos_r <= y_pos_r + STEP_Y;
      end
    end
  end

  // Pixel colour: erase paints background, draws follow the sprite mask.
  always_comb begin
    colour_s = BG_COLOUR;
    if (state_r == ST_ERASE) begin
      colour_s = BG_COLOUR;
    end else if (scan_s) begin
      colour_s = mask_bit_s ? FG_COLOUR : BG_COLOUR;
    end else begin
      colour_s = BG_COLOUR;
    end
  end

  assign bus.x_out    = BASE_X + X_W'(col_r);
  assign bus.y_out    = y_pos_r + Y_W'(row_r);
  assign bus.colour   = colour_s;
  assign bus.write_en = scan_s;
  assign bus.busy     = (state_r != ST_IDLE);
  assign bus.done     = (state_r == ST_DONE);
  assign bus.bump     = bump_s;
  assign bus.y_pos    = y_pos_r;

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Bench for player_sprite_ctrl: two instances (default sprite, and a 3x2
// sprite with step 2) checked cycle by cycle against a transaction model
// that expands each move into its expected pixel/status sequence.
module tb_player_sprite_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_sprite_ctrl_if #(.X_W(8), .Y_W(7)) bus0 ();
  player_sprite_ctrl_if #(.X_W(8), .Y_W(7)) bus1 ();

  player_sprite_ctrl dut0 (.clk(clk), .reset(reset), .bus(bus0));
  player_sprite_ctrl #(.SPR_W(3), .SPR_H(2), .SPR_MASK(6'b111010),
                       .Y_INIT(3), .Y_STEP(2))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Model parameters per instance.
  int p_w[2]    = '{2, 3};
  int p_h[2]    = '{3, 2};
  int p_mask[2] = '{12, 58};
  int p_step[2] = '{1, 2};
  int p_init[2] = '{58, 3};
  localparam int XPOS = 4;
  localparam int YMIN = 0;
  localparam int YMAX = 116;
  localparam int FG   = 7;
  localparam int BG   = 0;

  typedef struct {
    logic       we;
    logic       busy;
    logic       done;
    logic       bump;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [6:0] ypos;
  } rec_t;

  int   y_m[2];
  rec_t q0[$];
  rec_t q1[$];
  int   checks = 0;
  int   errors = 0;

  function automatic rec_t mk(bit we, bit busy, bit done, bit bump,
                              int x, int y, int c, int ypos);
    rec_t r;
    r.we = we; r.busy = busy; r.done = done; r.bump = bump;
    r.x = 8'(x); r.y = 7'(y); r.c = 3'(c); r.ypos = 7'(ypos);
    return r;
  endfunction

  function automatic void push(int s, rec_t r);
    if (s == 0) q0.push_back(r);
    else q1.push_back(r);
  endfunction

  function automatic rec_t idle_rec(int s, bit bump);
    return mk(1'b0, 1'b0, 1'b0, bump, 0, 0, 0, y_m[s]);
  endfunction

  // Whole sprite painted at top row ybase, left to right, top to bottom.
  function automatic void add_scan(int s, int ybase, bit erase);
    for (int r = 0; r < p_h[s]; r++) begin
      for (int c = 0; c < p_w[s]; c++) begin
        int col;
        col = erase ? BG : (((p_mask[s] >> (r * p_w[s] + c)) & 1) != 0 ? FG : BG);
        push(s, mk(1'b1, 1'b1, 1'b0, 1'b0, XPOS + c, ybase + r, col, y_m[s]));
      end
    end
  endfunction

  function automatic bit legal(int s, bit up);
    if (up) return y_m[s] >= YMIN + p_step[s];
    else return y_m[s] + p_step[s] <= YMAX;
  endfunction

  // Expected cycles of one accepted move, from erase to done.
  function automatic void add_move(int s, bit up);
    int yo;
    yo = y_m[s];
    add_scan(s, yo, 1'b1);
    push(s, mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, yo));
    y_m[s] = up ? yo - p_step[s] : yo + p_step[s];
    add_scan(s, y_m[s], 1'b0);
    push(s, mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, y_m[s]));
  endfunction

  function automatic void add_init(int s);
    add_scan(s, y_m[s], 1'b0);
    push(s, mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, y_m[s]));
    push(s, idle_rec(s, 1'b0));
  endfunction

  task automatic set_req(int s, bit up, bit dn);
    if (s == 0) begin bus0.p_up = up; bus0.p_down = dn; end
    else begin bus1.p_up = up; bus1.p_down = dn; end
  endtask

  task automatic check_rec(int s, rec_t e, bit full, string name);
    rec_t a;
    bit bad;
    if (s == 0) begin
      a.we = bus0.write_en; a.busy = bus0.busy; a.done = bus0.done;
      a.bump = bus0.bump; a.x = bus0.x_out; a.y = bus0.y_out;
      a.c = bus0.colour; a.ypos = bus0.y_pos;
    end else begin
      a.we = bus1.write_en; a.busy = bus1.busy; a.done = bus1.done;
      a.bump = bus1.bump; a.x = bus1.x_out; a.y = bus1.y_out;
      a.c = bus1.colour; a.ypos = bus1.y_pos;
    end
    bad = (a.we !== e.we) || (a.busy !== e.busy) || (a.done !== e.done) ||
          (a.bump !== e.bump) || (a.ypos !== e.ypos);
    if (e.we || full) begin
      bad = bad || (a.x !== e.x) || (a.y !== e.y) || (a.c !== e.c);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got we=%0b busy=%0b done=%0b bump=%0b x=%0d y=%0d c=%0d ypos=%0d; expected we=%0b busy=%0b done=%0b bump=%0b x=%0d y=%0d c=%0d ypos=%0d",
               name, s, $time, a.we, a.busy, a.done, a.bump, a.x, a.y, a.c, a.ypos,
               e.we, e.busy, e.done, e.bump, e.x, e.y, e.c, e.ypos);
    end
  endtask

  // Step both instances in lockstep through their expected sequences.
  task automatic run_queues(string name);
    while (q0.size() > 0 || q1.size() > 0) begin
      @(negedge clk);
      #1;
      if (q0.size() > 0) check_rec(0, q0.pop_front(), 1'b0, name);
      if (q1.size() > 0) check_rec(1, q1.pop_front(), 1'b0, name);
    end
  endtask

  // One-cycle request pulse in IDLE, then the full expected response.
  task automatic do_op(int s, bit up, bit dn, string name);
    @(negedge clk);
    set_req(s, up, dn);
    #1;
    if ((up ^ dn) && legal(s, up)) begin
      check_rec(s, idle_rec(s, 1'b0), 1'b0, {name, "_accept"});
      @(posedge clk);
      #1 set_req(s, 1'b0, 1'b0);
      add_move(s, up);
      push(s, idle_rec(s, 1'b0));
    end else begin
      check_rec(s, idle_rec(s, up ^ dn), 1'b0, {name, "_reject"});
      @(posedge clk);
      #1 set_req(s, 1'b0, 1'b0);
      push(s, idle_rec(s, 1'b0));
    end
    run_queues(name);
  endtask

  // Request held high: moves repeat with one IDLE cycle between them until
  // the limit, where the held request bumps instead.
  task automatic hold_dir(int s, bit up, string name);
    @(negedge clk);
    set_req(s, up, !up);
    #1;
    while (legal(s, up)) begin
      check_rec(s, idle_rec(s, 1'b0), 1'b0, {name, "_idle"});
      add_move(s, up);
      run_queues(name);
      @(negedge clk);
      #1;
    end
    check_rec(s, idle_rec(s, 1'b1), 1'b0, {name, "_limit_bump"});
    @(posedge clk);
    #1 set_req(s, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_rec(s, idle_rec(s, 1'b0), 1'b0, {name, "_released"});
    do_op(s, up, !up, {name, "_extra"});
  endtask

  task automatic release_and_init(string name);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check_rec(s, mk(1'b0, 1'b1, 1'b0, 1'b0, XPOS, y_m[s], BG, y_m[s]), 1'b1,
                {name, "_start"});
      add_init(s);
    end
    run_queues({name, "_init_draw"});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0);
    set_req(1, 1'b0, 1'b0);
    y_m[0] = p_init[0];
    y_m[1] = p_init[1];
    #3;
    for (int s = 0; s < 2; s++) begin
      check_rec(s, mk(1'b0, 1'b1, 1'b0, 1'b0, XPOS, y_m[s], BG, y_m[s]), 1'b1,
                "reset_values");
    end
    #20;
    release_and_init("reset");
  endtask

  task automatic test_up_pulse();
    do_op(0, 1'b1, 1'b0, "up_pulse");
  endtask

  task automatic test_both_high();
    do_op(0, 1'b1, 1'b1, "both_high");
    do_op(0, 1'b0, 1'b0, "no_request");
  endtask

  task automatic test_hold_limits();
    hold_dir(0, 1'b0, "hold_down");
    hold_dir(1, 1'b1, "hold_up_step2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int s;
      int r;
      s = $urandom_range(0, 1);
      r = $urandom_range(0, 3);
      case (r)
        0: do_op(s, 1'b1, 1'b0, "rand_up");
        1: do_op(s, 1'b0, 1'b1, "rand_down");
        2: do_op(s, 1'b1, 1'b1, "rand_both");
        default: do_op(s, 1'b0, 1'b0, "rand_none");
      endcase
    end
  endtask

  task automatic test_reset_mid_draw();
    bit up;
    up = legal(0, 1'b1);
    @(negedge clk);
    set_req(0, up, !up);
    @(posedge clk);
    #1 set_req(0, 1'b0, 1'b0);
    add_move(0, up);
    // erase pixels, update, then the first three draw pixels
    for (int i = 0; i < 6 + 1 + 3; i++) begin
      @(negedge clk);
      #1 check_rec(0, q0.pop_front(), 1'b0, "mid_draw_prefix");
    end
    q0.delete();
    #1 reset = 1'b1;
    #1;
    y_m[0] = p_init[0];
    y_m[1] = p_init[1];
    for (int s = 0; s < 2; s++) begin
      check_rec(s, mk(1'b0, 1'b1, 1'b0, 1'b0, XPOS, y_m[s], BG, y_m[s]), 1'b1,
                "mid_draw_async_reset");
    end
    @(negedge clk);
    release_and_init("mid_draw_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_up_pulse();
    test_both_high();
    test_hold_limits();
    test_random();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
